// File: rtl/uart_tx_axis_fifo_if.sv
// AXI-Stream byte channel between the producer, the FIFO and the UART transmitter.
// The master drives data and valid; the slave answers with ready.
interface uart_tx_axis_fifo_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/uart_tx_axis_fifo.sv
// First-word-fall-through elastic buffer ahead of the UART transmitter.
// Pointers carry a wrap bit, so occupancy is a plain modular subtraction.
module uart_tx_axis_fifo #(
    parameter int DATA_WIDTH          = 8,
    parameter int DEPTH               = 16,
    parameter int ALMOST_EMPTY_THRESH = 0,
    parameter int ALMOST_FULL_THRESH  = DEPTH - 2,
    localparam int AW                 = $clog2(DEPTH)
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic                   flush,
    uart_tx_axis_fifo_if.slave     s_axis,
    uart_tx_axis_fifo_if.master    m_axis,
    output logic                   fifo_almost_empty,
    output logic                   fifo_almost_full,
    output logic [AW:0]            fifo_count
);

    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AE_C    = (AW + 1)'(ALMOST_EMPTY_THRESH);
    localparam logic [AW:0] AF_C    = (AW + 1)'(ALMOST_FULL_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [AW:0] wr_ptr_q;
    logic [AW:0] wr_ptr_d;
    logic [AW:0] rd_ptr_q;
    logic [AW:0] rd_ptr_d;
    logic [AW:0] count;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;

    assign count = wr_ptr_q - rd_ptr_q;
    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    assign s_axis.tready = !full;
    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = mem_q[rd_ptr_q[AW-1:0]];

    assign fifo_count        = count;
    assign fifo_almost_empty = (count <= AE_C);
    assign fifo_almost_full  = (count >= AF_C);

    assign wr_en = s_axis.tvalid && !full;
    assign rd_en = m_axis.tready && !empty;

    // Flush beats any concurrent handshake: both pointers return to zero.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge aclk) begin
        if (wr_en && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_axis.tdata;
        end
    end

endmodule
